// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT frame collector and its bank storage.
package fft_pkg;

    localparam int unsigned DEFAULT_SAMPLE_SIZE = 32;

    typedef logic signed [DEFAULT_SAMPLE_SIZE-1:0] sample_t;

    typedef enum logic {
        S_FILL,
        S_WAIT
    } collector_state_e;

    typedef enum logic {
        EMPTY,
        FULL
    } bank_status_e;

    // Reverses the low 'width' bits of idx; bits above width come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(width)) begin
                r = {r[30:0], idx[i]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank: register array with a single write port and a flat read port
// exposing every slot at once.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int unsigned buffer_size = 32,
    parameter int unsigned sample_size = 32,
    localparam int unsigned AW = $clog2(buffer_size)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic [AW-1:0]                      wr_addr,
    input  logic [sample_size-1:0]             wr_data,
    output logic [buffer_size*sample_size-1:0] rd_data
);

    logic [buffer_size*sample_size-1:0] data_q;
    logic [buffer_size*sample_size-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            data_d[wr_addr*sample_size +: sample_size] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_data = data_q;

endmodule

// File: rtl/fft_frame_collector.sv
// Collects audio samples into ping-pong frame banks and hands complete frames to the FFT.
// Define FFT_COLLECT_BITREV_EN to store samples in bit-reversed (decimation-in-time) slot order.
module fft_frame_collector
    import fft_pkg::*;
#(
    parameter int unsigned buffer_size = 32,
    parameter int unsigned sample_size = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [sample_size-1:0]             sample_in,
    input  logic                               sample_valid,
    output logic                               sample_ready,
    output logic [buffer_size*sample_size-1:0] frame_real,
    output logic [buffer_size*sample_size-1:0] frame_imag,
    output logic                               frame_valid,
    input  logic                               frame_ready,
    output logic [15:0]                        overrun_count,
    output collector_state_e                   state_dbg
);

    localparam int unsigned AW = $clog2(buffer_size);
    localparam int unsigned FW = buffer_size * sample_size;

    collector_state_e state_q, state_d;
    bank_status_e     status_q [2];
    bank_status_e     status_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [AW-1:0]    wr_idx_q, wr_idx_d;
    logic [15:0]      overrun_q, overrun_d;
    logic             frame_valid_q, frame_valid_d;
    logic [FW-1:0]    frame_real_q, frame_real_d;

    logic [AW-1:0]    wr_addr;
    logic [FW-1:0]    bank_rdata [2];
    logic [FW-1:0]    merged;
    logic [1:0]       bank_we;
    logic             wr_en;
    logic             consume;
    logic             complete;

    always_comb begin
`ifdef FFT_COLLECT_BITREV_EN
        wr_addr = AW'(bitrev(32'(wr_idx_q), AW));
`else
        wr_addr = wr_idx_q;
`endif
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .buffer_size(buffer_size),
            .sample_size(sample_size)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (bank_we[b]),
            .wr_addr(wr_addr),
            .wr_data(sample_in),
            .rd_data(bank_rdata[b])
        );
    end

    // Output handshake: a frame transfers on any rising edge where frame_valid and
    // frame_ready are both 1; frame_real holds steady while valid is up and ready is low.
    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        wr_idx_d      = wr_idx_q;
        overrun_d     = overrun_q;
        bank_we       = '0;

        wr_en    = (state_q == S_FILL) && sample_valid;
        consume  = frame_valid_q && frame_ready;
        complete = wr_en && (wr_idx_q == AW'(buffer_size - 1));

        bank_we[wr_bank_q] = wr_en;
        if (wr_en) begin
            wr_idx_d = wr_idx_q + 1'b1;
        end
        if (consume) begin
            status_d[rd_bank_q] = EMPTY;
            rd_bank_d           = ~rd_bank_q;
        end
        if (complete) begin
            status_d[wr_bank_q] = FULL;
            wr_bank_d           = ~wr_bank_q;
        end

        // status_d already reflects a same-edge consume, so a bank freed now never blocks.
        case (state_q)
            S_FILL: begin
                if (complete && (status_d[wr_bank_d] == FULL)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sample_valid && (overrun_q != 16'hFFFF)) begin
                    overrun_d = overrun_q + 16'd1;
                end
                if (status_d[wr_bank_q] == EMPTY) begin
                    state_d  = S_FILL;
                    wr_idx_d = '0;
                end
            end
            default: state_d = S_FILL;
        endcase

        // Forward the sample being written so a frame completing on the consume edge shows up intact.
        merged = bank_rdata[rd_bank_d];
        if (wr_en && (wr_bank_q == rd_bank_d)) begin
            merged[wr_addr*sample_size +: sample_size] = sample_in;
        end

        frame_valid_d = consume ? (status_d[rd_bank_d] == FULL) : (status_q[rd_bank_q] == FULL);
        frame_real_d  = frame_valid_d ? merged : frame_real_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FILL;
            status_q      <= '{EMPTY, EMPTY};
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_idx_q      <= '0;
            overrun_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_real_q  <= '0;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_idx_q      <= wr_idx_d;
            overrun_q     <= overrun_d;
            frame_valid_q <= frame_valid_d;
            frame_real_q  <= frame_real_d;
        end
    end

    assign sample_ready  = 1'b1;
    assign frame_real    = frame_real_q;
    assign frame_imag    = '0;
    assign frame_valid   = frame_valid_q;
    assign overrun_count = overrun_q;
    assign state_dbg     = state_q;

endmodule
